seven_seg_scan_decoder: RTL
===========================

# seven_seg_scan_decoder

Reads the multiplexed seven-segment bus produced by the parking meter display driver: the active-low anodes and active-low cathodes. It reconstructs the four BCD digits and classifies the flash behaviour as dark, steady, fast flash or slow flash. It sits alongside the parking meter as an on-board self-check and bench monitor, so displayed time can be compared against the meter's internal counter without touching its internals.

## Interface
- FAST_MAX, 75: longest blank run, in cycles, classed as fast flash.
- DARK_MIN, 255: blank-run length at which the display is declared dark (saturation value of the run counter).
- STEADY_MIN, 250: consecutive lit cycles with no blank run before the display is declared steady.
- clk  input  1  system clock, 100 Hz in the meter build.
- rst  input  1  synchronous, active-high reset.
- led_anodes  input  4  active-low digit enables: 1110 ones, 1101 tens, 1011 hundreds, 0111 thousands, 1111 blank.
- led_cathodes  input  7  active-low segments a..g, MSB = a.
- val1  output  4  recovered thousands digit.
- val2  output  4  recovered hundreds digit.
- val3  output  4  recovered tens digit.
- val4  output  4  recovered ones digit.
- frame_valid  output  1  one-cycle pulse; val1..val4 were just updated from a complete frame.
- digit_err  output  1  one-cycle pulse on an illegal anode code or an unrecognised cathode pattern.
- disp_state  output  2  0 DARK, 1 STEADY, 2 FLASH_FAST, 3 FLASH_SLOW.
- order_err  output  1  one-cycle pulse on an out-of-order scan (see Configuration).

## Operation
- Stage 1 registers led_anodes and led_cathodes.
- Stage 2 decodes the registered sample.
- Cathode legend: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
- Legal anode code with a legal pattern: write the digit into the shadow register for that position and set its bit in a 4-bit seen mask.
- Legal anode code with any other pattern: digit_err pulses; the shadow register and mask are unchanged.
- Anode code other than the four digit codes and 1111: digit_err pulses; the sample is ignored.
- Anode 1111 is a blank sample. It is not an error and does not alter the mask.
- Frame completion: when the mask reaches 1111, including the update made by the current sample, copy the shadows to val1..val4, pulse frame_valid and clear the mask. The current sample is included in the copy.
- Repeated capture of the same position before the frame completes overwrites that shadow. The last value wins.
- Flash classifier counters:
  - blank_run: 8-bit, saturating at DARK_MIN.
  - lit_run: 8-bit, saturating at STEADY_MIN.
- On a blank sample, blank_run increments and lit_run clears. When blank_run reaches DARK_MIN, disp_state becomes DARK.
- On a lit sample that follows a blank run of length L, with 0 < L < DARK_MIN:
  - L ≤ FAST_MAX: disp_state becomes FLASH_FAST.
  - otherwise: disp_state becomes FLASH_SLOW.
  - In both cases blank_run then clears.
- During a lit run, lit_run increments. When it reaches STEADY_MIN, disp_state becomes STEADY.
- Simultaneous events: a completed blank run and a frame completion on the same cycle are independent; both take effect.
- Reset values:
  - val1..val4 = 0; frame_valid, digit_err and order_err = 0; disp_state = DARK.
  - Mask and both counters cleared.
  - Pipeline registers loaded with anodes 1111 and cathodes 1111111.

## Timing
- Latency is 2 clocks from the input sample to its effect on any output. A sample present at edge N is registered at N and acted on at N+1.
- frame_valid, digit_err and order_err are high for exactly one cycle per event.
- val1..val4 hold their values between frame_valid pulses.
- The disp_state transition appears on the same edge as the triggering decode.
- rst mid-frame discards the partial frame and clears the mask. The first frame_valid after reset requires all four positions to be captured again.
- No handshake: the block is a passive monitor with no back-pressure.

## Configuration
- SCAN_ORDER_CHECK_EN defined:
  - The block tracks the last captured position.
  - The next legal capture must be the next position in the order ones → tens → hundreds → thousands → ones. Blank samples in between are allowed.
  - A violation pulses order_err and resynchronises tracking to the new position. Digit capture is unaffected.
  - The first capture after reset is never an error.
- SCAN_ORDER_CHECK_EN undefined: order_err is tied to 0 and the tracking logic is absent.

## Structure
- The shared package parking_meter_pkg holds:
  - the ten cathode pattern constants and the blank pattern;
  - the four anode codes and the blank anode code;
  - the disp_state enumeration.
- One sub-module, seg7_pattern_decode: combinational, 7-bit pattern in, 4-bit digit out plus a valid flag.
- The classifier and frame assembly stay in the top module.

## Test plan
- Scan the digits 1,2,3,4 into thousands..ones, one cycle each, repeated, with no blanks → frame_valid every 4 cycles; val1..val4 = 1,2,3,4; disp_state reaches STEADY after 250 lit cycles.
- Repeat the lit scan of 0,0,1,6, then blank for 50 cycles, in a 200-cycle loop → disp_state = FLASH_FAST after the first blank run ends.
- Lit scan for 100 cycles, then blank for 100 cycles, repeated → disp_state = FLASH_SLOW.
- Continuous blank for 300 cycles from steady → disp_state = DARK at blank cycle 255; no frame_valid and no digit_err.
- Anode 1110 with cathode 1111110 → digit_err pulse; val4 unchanged; frame not completed. Then anode 0011 → another digit_err pulse.
- With SCAN_ORDER_CHECK_EN: scan ones, then hundreds → order_err pulses once; the next tens capture also pulses order_err; ones→tens→hundreds→thousands thereafter → no further pulses. Assert rst mid-frame → no frame_valid until all four positions are rescanned.

Source files
------------

// File: rtl/parking_meter_pkg.sv
// Shared display-bus constants: cathode patterns, anode codes, display-state encoding.
package parking_meter_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned DIGIT_W = 4;

    // Active-low segments a..g, MSB = a
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [AN_W-1:0] AN_ONES      = 4'b1110;
    localparam logic [AN_W-1:0] AN_TENS      = 4'b1101;
    localparam logic [AN_W-1:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [AN_W-1:0] AN_THOUSANDS = 4'b0111;
    localparam logic [AN_W-1:0] AN_BLANK     = 4'b1111;

    typedef enum logic [1:0] {
        DISP_DARK       = 2'd0,
        DISP_STEADY     = 2'd1,
        DISP_FLASH_FAST = 2'd2,
        DISP_FLASH_SLOW = 2'd3
    } disp_state_t;

    typedef struct packed {
        logic [AN_W-1:0]  anodes;
        logic [SEG_W-1:0] cathodes;
    } seg_sample_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational cathode-pattern to BCD digit lookup; valid_c low for any non-digit pattern.
module seg7_pattern_decode
    import parking_meter_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic [DIGIT_W-1:0] digit_c,
    output logic               valid_c
);

    always_comb begin
        digit_c = '0;
        valid_c = 1'b1;
        case (pattern)
            SEG_0:   digit_c = DIGIT_W'(0);
            SEG_1:   digit_c = DIGIT_W'(1);
            SEG_2:   digit_c = DIGIT_W'(2);
            SEG_3:   digit_c = DIGIT_W'(3);
            SEG_4:   digit_c = DIGIT_W'(4);
            SEG_5:   digit_c = DIGIT_W'(5);
            SEG_6:   digit_c = DIGIT_W'(6);
            SEG_7:   digit_c = DIGIT_W'(7);
            SEG_8:   digit_c = DIGIT_W'(8);
            SEG_9:   digit_c = DIGIT_W'(9);
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Passive monitor of the multiplexed 7-seg bus: rebuilds four BCD digits and classifies flashing.
// Optional scan-order checking is enabled by defining SCAN_ORDER_CHECK_EN.
module seven_seg_scan_decoder
    import parking_meter_pkg::*;
#(
    parameter int unsigned FAST_MAX   = 75,
    parameter int unsigned DARK_MIN   = 255,
    parameter int unsigned STEADY_MIN = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AN_W-1:0]    led_anodes,
    input  logic [SEG_W-1:0]   led_cathodes,
    output logic [DIGIT_W-1:0] val1,
    output logic [DIGIT_W-1:0] val2,
    output logic [DIGIT_W-1:0] val3,
    output logic [DIGIT_W-1:0] val4,
    output logic               frame_valid,
    output logic               digit_err,
    output logic [1:0]         disp_state,
    output logic               order_err
);

    localparam int unsigned RUN_W   = 8;
    localparam int unsigned POS_W   = 2;
    localparam int unsigned NUM_POS = 4;

    localparam logic [RUN_W-1:0] FAST_LIM   = RUN_W'(FAST_MAX);
    localparam logic [RUN_W-1:0] DARK_LIM   = RUN_W'(DARK_MIN);
    localparam logic [RUN_W-1:0] STEADY_LIM = RUN_W'(STEADY_MIN);

    // Stage 1: input sample register, reset to a blank sample
    seg_sample_t sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '{anodes: AN_BLANK, cathodes: SEG_BLANK};
        end else begin
            sample_q <= '{anodes: led_anodes, cathodes: led_cathodes};
        end
    end

    logic [DIGIT_W-1:0] digit_c;
    logic               pattern_ok_c;

    seg7_pattern_decode u_pattern_decode (
        .pattern (sample_q.cathodes),
        .digit_c (digit_c),
        .valid_c (pattern_ok_c)
    );

    // Anode code to digit position (0 = ones .. 3 = thousands)
    logic [POS_W-1:0] pos_c;
    logic             is_digit_c;
    logic             is_blank_c;

    always_comb begin
        pos_c      = '0;
        is_digit_c = 1'b1;
        is_blank_c = 1'b0;
        case (sample_q.anodes)
            AN_ONES:      pos_c = POS_W'(0);
            AN_TENS:      pos_c = POS_W'(1);
            AN_HUNDREDS:  pos_c = POS_W'(2);
            AN_THOUSANDS: pos_c = POS_W'(3);
            AN_BLANK: begin
                is_digit_c = 1'b0;
                is_blank_c = 1'b1;
            end
            default:      is_digit_c = 1'b0;
        endcase
    end

    // Stage 2: frame assembly and flash classifier
    logic [NUM_POS-1:0][DIGIT_W-1:0] shadow_q, shadow_n;
    logic [NUM_POS-1:0][DIGIT_W-1:0] val_q, val_n;
    logic [NUM_POS-1:0]              mask_q, mask_n, mask_upd_c;
    logic [RUN_W-1:0]                blank_q, blank_n;
    logic [RUN_W-1:0]                lit_q, lit_n;
    logic                            frame_q, frame_n;
    logic                            derr_q, derr_n;
    disp_state_t                     state_q, state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            val_q    <= '0;
            mask_q   <= '0;
            blank_q  <= '0;
            lit_q    <= '0;
            frame_q  <= 1'b0;
            derr_q   <= 1'b0;
            state_q  <= DISP_DARK;
        end else begin
            shadow_q <= shadow_n;
            val_q    <= val_n;
            mask_q   <= mask_n;
            blank_q  <= blank_n;
            lit_q    <= lit_n;
            frame_q  <= frame_n;
            derr_q   <= derr_n;
            state_q  <= state_n;
        end
    end

    always_comb begin
        shadow_n   = shadow_q;
        val_n      = val_q;
        mask_n     = mask_q;
        mask_upd_c = mask_q;
        blank_n    = blank_q;
        lit_n      = lit_q;
        frame_n    = 1'b0;
        derr_n     = 1'b0;
        state_n    = state_q;

        if (is_blank_c) begin
            lit_n = '0;
            if (blank_q != DARK_LIM) begin
                blank_n = blank_q + RUN_W'(1);
            end
            if (blank_n == DARK_LIM) begin
                state_n = DISP_DARK;
            end
        end else if (is_digit_c) begin
            // A lit sample closes any blank run shorter than the dark threshold
            if ((blank_q != '0) && (blank_q < DARK_LIM)) begin
                state_n = (blank_q <= FAST_LIM) ? DISP_FLASH_FAST : DISP_FLASH_SLOW;
            end
            blank_n = '0;
            if (lit_q != STEADY_LIM) begin
                lit_n = lit_q + RUN_W'(1);
            end
            if (lit_n == STEADY_LIM) begin
                state_n = DISP_STEADY;
            end

            if (pattern_ok_c) begin
                shadow_n[pos_c] = digit_c;
                mask_upd_c      = mask_q | (NUM_POS'(1) << pos_c);
                if (&mask_upd_c) begin
                    val_n   = shadow_n;
                    frame_n = 1'b1;
                    mask_n  = '0;
                end else begin
                    mask_n  = mask_upd_c;
                end
            end else begin
                derr_n = 1'b1;
            end
        end else begin
            derr_n = 1'b1;
        end
    end

`ifdef SCAN_ORDER_CHECK_EN
    // Expected scan order ones -> tens -> hundreds -> thousands -> ones
    logic             capture_c;
    logic [POS_W-1:0] last_q;
    logic             tracked_q;
    logic             order_q;

    assign capture_c = is_digit_c & pattern_ok_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= '0;
            tracked_q <= 1'b0;
            order_q   <= 1'b0;
        end else begin
            order_q <= 1'b0;
            if (capture_c) begin
                order_q   <= tracked_q && (pos_c != POS_W'(last_q + POS_W'(1)));
                last_q    <= pos_c;
                tracked_q <= 1'b1;
            end
        end
    end

    assign order_err = order_q;
`else
    assign order_err = 1'b0;
`endif

    assign val1        = val_q[3];
    assign val2        = val_q[2];
    assign val3        = val_q[1];
    assign val4        = val_q[0];
    assign frame_valid = frame_q;
    assign digit_err   = derr_q;
    assign disp_state  = state_q;

endmodule
